// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel, runtime-configurable edge detector for
// asynchronous inputs (buttons, external strobes, status lines).
//
// Each channel runs its raw input through a SYNC_STAGES-deep synchroniser and
// a debounce filter. The filter accepts a new level only after the
// synchronised input has differed from the current level for L+1
// consecutive cycles, where L = filt_len_i.
//
// Accepted level changes ("updates") can raise a one-cycle pulse, selected
// per channel by the edge mode. A pulse also sets a sticky pending flag,
// which is cleared by writing 1 to clr_i.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   in_i        [CH]       raw asynchronous inputs
//   mode_i      [2*CH]     per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   filt_len_i  [FILT_W]   debounce length L, shared by all channels
//   clr_i       [CH]       write-1-to-clear for pending, level-sensitive
//   level_o     [CH]       filtered, debounced level
//   pulse_o     [CH]       one-cycle edge pulse
//   pending_o   [CH]       sticky edge-event flags
//   irq_o                  OR of all pending bits
module edge_detect_multi #(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       in_i,
  input  logic [2*CH-1:0]     mode_i,
  input  logic [FILT_W-1:0]   filt_len_i,
  input  logic [CH-1:0]       clr_i,
  output logic [CH-1:0]       level_o,
  output logic [CH-1:0]       pulse_o,
  output logic [CH-1:0]       pending_o,
  output logic                irq_o
);

  // Synchroniser chain; index 0 samples the raw input, the last stage is
  // the clean signal seen by the filter.
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0]                  sync_s;

  // Debounce state.
  logic [CH-1:0][FILT_W-1:0]      cnt_q,     cnt_d;
  logic [CH-1:0]                  level_q,   level_d;

  // Event outputs.
  logic [CH-1:0]                  pulse_q,   pulse_d;
  logic [CH-1:0]                  pending_q, pending_d;
  logic                           irq_q,     irq_d;

  // Per-channel filter acceptance strobe for the current cycle.
  logic [CH-1:0]                  update;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  // Debounce filter, pulse generation and pending/irq next state.
  // The >= compare means a filt_len_i lowered below an in-flight count
  // completes on the very next cycle rather than stranding the counter.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = '0;
    pulse_d = '0;

    for (int unsigned i = 0; i < CH; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len_i) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
        update[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end

      // The new level tells the edge direction: 1 = rising, 0 = falling.
      pulse_d[i] = update[i] &
                   ((sync_s[i] & mode_i[2*i]) | (~sync_s[i] & mode_i[2*i+1]));
    end

    // Set has priority over a simultaneous clear.
    pending_d = (pending_q & ~clr_i) | pulse_d;
    irq_d     = |pending_d;
  end

  // Filter and event state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi (CH=8, SYNC_STAGES=2, FILT_W=4).
// Vectors are driven just after a rising edge; the expected outputs after the
// following rising edge are queued and compared by a monitor 1 time unit
// after that edge.
module tb_edge_detect_multi;

  localparam int unsigned CH = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned FW = 4;

  localparam logic [15:0] MODE_A = 16'h54E5; // ch2 fall, ch3 both, ch4 off, rest rise
  localparam logic [15:0] MODE_B = 16'h5555; // all rise

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]     in_v;
  logic [2*CH-1:0]   mode_v;
  logic [FW-1:0]     filt_v;
  logic [CH-1:0]     clr_v;
  logic [CH-1:0]     level_o;
  logic [CH-1:0]     pulse_o;
  logic [CH-1:0]     pending_o;
  logic              irq_o;

  edge_detect_multi #(
    .CH          (CH),
    .SYNC_STAGES (SS),
    .FILT_W      (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_i       (in_v),
    .mode_i     (mode_v),
    .filt_len_i (filt_v),
    .clr_i      (clr_v),
    .level_o    (level_o),
    .pulse_o    (pulse_o),
    .pending_o  (pending_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic [15:0] mode;
    logic [3:0]  filt;
    logic [7:0]  clr;
    logic [7:0]  lvl;
    logic [7:0]  pls;
    logic [7:0]  pnd;
  } vec_t;

  typedef struct {
    logic [7:0] lvl;
    logic [7:0] pls;
    logic [7:0] pnd;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void check(string tag, logic [7:0] lvl, logic [7:0] pls,
                                logic [7:0] pnd);
    logic irq_exp;
    irq_exp = |pnd;
    n_total++;
    if (level_o === lvl && pulse_o === pls && pending_o === pnd && irq_o === irq_exp)
      n_pass++;
    else
      $display("FAIL %s: got level=%h pulse=%h pending=%h irq=%b, want level=%h pulse=%h pending=%h irq=%b",
               tag, level_o, pulse_o, pending_o, irq_o, lvl, pls, pnd, irq_exp);
  endfunction

  task automatic add(int n, logic [7:0] din, logic [15:0] mode, logic [3:0] filt,
                     logic [7:0] clr, logic [7:0] lvl, logic [7:0] pls, logic [7:0] pnd);
    vec_t v;
    v.din = din; v.mode = mode; v.filt = filt; v.clr = clr;
    v.lvl = lvl; v.pls = pls; v.pnd = pnd;
    repeat (n) tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the
  // next rising edge.
  task automatic apply(string tag, logic [7:0] din, logic [15:0] mode, logic [3:0] filt,
                       logic [7:0] clr, logic [7:0] lvl, logic [7:0] pls, logic [7:0] pnd);
    exp_t e;
    @(posedge clk);
    #2;
    in_v   = din;
    mode_v = mode;
    filt_v = filt;
    clr_v  = clr;
    e.lvl = lvl; e.pls = pls; e.pnd = pnd; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected results left unchecked, want 0", exp_q.size());
  endtask

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, mon_e.lvl, mon_e.pls, mon_e.pnd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_v = '0; mode_v = '0; filt_v = '0; clr_v = '0;

    // Reset and idle.
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) apply("idle", 8'h00, 16'h0000, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset asserted while ch0 is mid-filter: nothing may appear afterwards.
    for (int i = 0; i < 4; i++) apply("rst_mid", 8'h01, MODE_A, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00);
    drain();
    rst = 1'b1;
    in_v = '0;
    #1;
    check("rst_async", 8'h00, 8'h00, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", 8'h00, 8'h00, 8'h00);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) apply("rst_release", 8'h00, MODE_A, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00);

    //  n   din    mode    L  clr    level  pulse  pending
    // ch0 rise latency with L=3, then clear, then fall (no pulse)
    add(5, 8'h01, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h01, MODE_A, 3, 8'h00, 8'h01, 8'h01, 8'h01);
    add(1, 8'h01, MODE_A, 3, 8'h00, 8'h01, 8'h00, 8'h01);
    add(1, 8'h01, MODE_A, 3, 8'h01, 8'h01, 8'h00, 8'h00);
    add(5, 8'h00, MODE_A, 3, 8'h00, 8'h01, 8'h00, 8'h00);
    add(1, 8'h00, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    // ch1 glitch of 3 cycles rejected, 4 cycles accepted
    add(3, 8'h02, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    add(4, 8'h00, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    add(4, 8'h02, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h00, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h00, MODE_A, 3, 8'h00, 8'h02, 8'h02, 8'h02);
    add(3, 8'h00, MODE_A, 3, 8'h00, 8'h02, 8'h00, 8'h02);
    add(1, 8'h00, MODE_A, 3, 8'h00, 8'h00, 8'h00, 8'h02);
    add(1, 8'h00, MODE_A, 3, 8'h02, 8'h00, 8'h00, 8'h00);
    // modes with L=0: ch2 fall, ch3 both, ch4 off
    add(2, 8'h1C, MODE_A, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h1C, MODE_A, 0, 8'h00, 8'h1C, 8'h08, 8'h08);
    add(2, 8'h00, MODE_A, 0, 8'h00, 8'h1C, 8'h00, 8'h08);
    add(1, 8'h00, MODE_A, 0, 8'h00, 8'h00, 8'h0C, 8'h0C);
    add(1, 8'h00, MODE_A, 0, 8'h00, 8'h00, 8'h00, 8'h0C);
    add(1, 8'h00, MODE_A, 0, 8'h0C, 8'h00, 8'h00, 8'h00);
    // ch5 set wins over clear, then clear alone, then held clear on a 0 bit
    add(2, 8'h20, MODE_A, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'h20, MODE_A, 0, 8'h00, 8'h20, 8'h20, 8'h20);
    add(2, 8'h00, MODE_A, 0, 8'h00, 8'h20, 8'h00, 8'h20);
    add(2, 8'h20, MODE_A, 0, 8'h00, 8'h00, 8'h00, 8'h20);
    add(1, 8'h20, MODE_A, 0, 8'h20, 8'h20, 8'h20, 8'h20);
    add(2, 8'h20, MODE_A, 0, 8'h20, 8'h20, 8'h00, 8'h00);
    add(2, 8'h00, MODE_A, 0, 8'h00, 8'h20, 8'h00, 8'h00);
    add(1, 8'h00, MODE_A, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // all channels rise together; the mode change itself must not pulse
    add(2, 8'hFF, MODE_B, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 8'hFF, MODE_B, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF);
    add(1, 8'hFF, MODE_B, 0, 8'h00, 8'hFF, 8'h00, 8'hFF);
    add(1, 8'hFF, MODE_B, 0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    add(2, 8'h00, MODE_B, 0, 8'h00, 8'hFF, 8'h00, 8'h00);
    add(2, 8'h00, MODE_B, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("row%0d", i), tbl[i].din, tbl[i].mode, tbl[i].filt, tbl[i].clr,
            tbl[i].lvl, tbl[i].pls, tbl[i].pnd);

    // Lowering filt_len from 15 to 2 with ch6 count at 10 accepts next cycle.
    for (int i = 0; i < 12; i++) apply("filt15", 8'h40, MODE_B, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00);
    apply("filt_drop",  8'h40, MODE_B, 4'd2, 8'h00, 8'h40, 8'h40, 8'h40);
    apply("filt_after", 8'h40, MODE_B, 4'd2, 8'h00, 8'h40, 8'h00, 8'h40);
    apply("filt_clr",   8'h40, MODE_B, 4'd2, 8'h40, 8'h40, 8'h00, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
